// File: rtl/apb4_timer_arb.sv
// apb4_timer_arb: round-robin arbiter serialising NREQ command channels onto one APB4 master port
module apb4_timer_arb #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NREQ-1:0]                req_valid_i,
  output logic [NREQ-1:0]                req_ready_o,
  input  logic [NREQ-1:0]                req_write_i,
  input  logic [NREQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NREQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NREQ*DATA_WIDTH/8-1:0]   req_strb_i,
  output logic [NREQ-1:0]                resp_valid_o,
  output logic [DATA_WIDTH-1:0]          resp_rdata_o,
  output logic                           resp_err_o,
  output logic [ADDR_WIDTH-1:0]          paddr_o,
  output logic                           pwrite_o,
  output logic [DATA_WIDTH-1:0]          pwdata_o,
  output logic [DATA_WIDTH/8-1:0]        pstrb_o,
  output logic [2:0]                     pprot_o,
  output logic                           psel_o,
  output logic                           penable_o,
  input  logic                           pready_i,
  input  logic [DATA_WIDTH-1:0]          prdata_i,
  input  logic                           pslverr_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, gnt_idx, cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, resp_rdata_q, resp_rdata_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d, resp_err_q, resp_err_d, tmo;
  logic [NREQ-1:0] req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  always_comb begin
    gnt_idx = last_q;
    cand = last_q;
    // Scan from farthest to nearest so the first requester after last_q wins
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (req_valid_i[cand]) gnt_idx = cand;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    pwrite_d = pwrite_q;
    psel_d = psel_q;
    penable_d = penable_q;
    req_ready_d = '0;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      IDLE: if (|req_valid_i) begin
        state_d = SETUP;
        last_d = gnt_idx;
        req_ready_d = NREQ'(1) << gnt_idx;
        pwrite_d = req_write_i[gnt_idx];
        paddr_d = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        pwdata_d = req_wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        pstrb_d = req_strb_i[int'(gnt_idx)*SW +: SW];
        psel_d = 1'b1;
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
        cnt_d = '0;
      end
      ACCESS: if (tmo || pready_i) begin
        state_d = IDLE;
        psel_d = 1'b0;
        penable_d = 1'b0;
        resp_valid_d = NREQ'(1) << last_q;
        resp_err_d = tmo ? 1'b1 : pslverr_i;
        resp_rdata_d = (!tmo && !pwrite_q) ? prdata_i : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q <= IW'(NREQ - 1);
      cnt_q <= '0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      pwrite_q <= 1'b0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      req_ready_q <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      pwrite_q <= pwrite_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q <= resp_err_d;
    end
  end
  assign req_ready_o = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o = resp_err_q;
  assign paddr_o = paddr_q;
  assign pwrite_o = pwrite_q;
  assign pwdata_o = pwdata_q;
  assign pstrb_o = pstrb_q;
  assign pprot_o = 3'b000;
  assign psel_o = psel_q;
  assign penable_o = penable_q;
endmodule

// File: tb/tb_apb4_timer_arb.sv
// tb_apb4_timer_arb: directed cycle-level bench for apb4_timer_arb with TIMEOUT=8
module tb_apb4_timer_arb;
  localparam int N = 4, AW = 32, DW = 32, TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_write = '0, resp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*DW/8-1:0] req_strb = '0;
  logic [DW-1:0] resp_rdata, pwdata, prdata = '0;
  logic [AW-1:0] paddr;
  logic [DW/8-1:0] pstrb;
  logic [2:0] pprot;
  logic resp_err, pwrite, psel, penable, pready = 1'b0, pslverr = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [N-1:0] g, seen;
  apb4_timer_arb #(.NREQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_strb_i(req_strb), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .pstrb_o(pstrb), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic set_req(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[r] = 1'b1;
    req_write[r] = w;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_strb[r*4 +: 4] = 4'hF;
  endtask
  task automatic wait_ready(output logic [N-1:0] r);
    r = '0;
    for (int i = 0; i < 10; i++) if (r == '0) begin
      tick();
      r = req_ready;
    end
  endtask
  // Zero-wait transfer started from an IDLE cycle; response lands in cycle 3
  task automatic xfer(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic slv, input logic [31:0] rd, input logic [31:0] exp_rd,
                      input logic exp_err);
    set_req(r, w, a, d);
    tick();
    check("x_ready", req_ready, 4'b1 << r);
    check("x_setup_psel", psel, 1);
    check("x_setup_penable", penable, 0);
    check("x_paddr", paddr, a);
    check("x_pwrite", pwrite, w);
    check("x_pwdata", pwdata, d);
    check("x_pstrb", pstrb, 4'hF);
    req_valid[r] = 1'b0;
    pready = 1'b1;
    pslverr = slv;
    prdata = rd;
    tick();
    check("x_access_psel", psel, 1);
    check("x_access_penable", penable, 1);
    check("x_access_rdy", req_ready, 0);
    tick();
    pready = 1'b0;
    pslverr = 1'b0;
    check("x_resp_valid", resp_valid, 4'b1 << r);
    check("x_resp_err", resp_err, exp_err);
    check("x_resp_rdata", resp_rdata, exp_rd);
    check("x_idle_psel", psel, 0);
  endtask
  initial begin
    tick();
    tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_ready", req_ready, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pprot", pprot, 0);
    rst = 1'b0;
    xfer(0, 1'b1, 32'h04, 32'h0000_00FF, 1'b0, 32'hAAAA_5555, 32'h0, 1'b0);
    set_req(2, 1'b0, 32'h08, 32'h0);
    tick();
    check("w2_ready", req_ready, 4'b0100);
    check("w2_pwrite", pwrite, 0);
    check("w2_paddr", paddr, 32'h08);
    req_valid[2] = 1'b0;
    tick();
    check("w2_c2_penable", penable, 1);
    tick();
    check("w2_c3_penable", penable, 1);
    check("w2_c3_resp", resp_valid, 0);
    tick();
    check("w2_c4_penable", penable, 1);
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    tick();
    pready = 1'b0;
    check("w2_resp", resp_valid, 4'b0100);
    check("w2_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("w2_err", resp_err, 0);
    xfer(3, 1'b1, 32'h10, 32'h55, 1'b1, 32'h0, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h1234, 32'h1234, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 + 32'(i) * 4, 32'h0);
    for (int i = 0; i < N; i++) begin
      wait_ready(g);
      check("rr_grant", g, 4'b1 << i);
      check("rr_paddr", paddr, 32'h100 + 32'(i) * 4);
      req_valid = req_valid & ~g;
    end
    set_req(1, 1'b0, 32'h200, 32'h0);
    set_req(3, 1'b0, 32'h204, 32'h0);
    wait_ready(g);
    check("rr2_first", g, 4'b0010);
    req_valid = req_valid & ~g;
    wait_ready(g);
    check("rr2_second", g, 4'b1000);
    req_valid = req_valid & ~g;
    tick();
    tick();
    tick();
    pready = 1'b0;
    set_req(1, 1'b0, 32'h20, 32'h0);
    prdata = 32'h1234_5678;
    tick();
    check("to_ready", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    for (int c = 2; c <= TO + 2; c++) begin
      tick();
      check("to_psel_held", psel, 1);
      check("to_no_resp", resp_valid, 0);
    end
    tick();
    check("to_resp", resp_valid, 4'b0010);
    check("to_err", resp_err, 1);
    check("to_rdata", resp_rdata, 0);
    check("to_psel_drop", psel, 0);
    pready = 1'b1;
    tick();
    pready = 1'b0;
    tick();
    check("to_late_resp", resp_valid, 0);
    check("to_late_psel", psel, 0);
    set_req(0, 1'b1, 32'h30, 32'h99);
    tick();
    check("mr_ready", req_ready, 4'b0001);
    req_valid[0] = 1'b0;
    tick();
    check("mr_access", penable, 1);
    rst = 1'b1;
    tick();
    check("mr_psel", psel, 0);
    check("mr_penable", penable, 0);
    check("mr_paddr", paddr, 0);
    check("mr_pwdata", pwdata, 0);
    check("mr_pwrite", pwrite, 0);
    check("mr_pstrb", pstrb, 0);
    check("mr_resp", resp_valid, 0);
    rst = 1'b0;
    pready = 1'b1;
    seen = '0;
    repeat (4) begin
      tick();
      seen = seen | resp_valid;
    end
    check("mr_no_resp", seen, 0);
    set_req(0, 1'b0, 32'h40, 32'h0);
    set_req(1, 1'b0, 32'h44, 32'h0);
    wait_ready(g);
    check("mr_next_grant", g, 4'b0001);
    req_valid = req_valid & ~g;
    wait_ready(g);
    check("mr_then_1", g, 4'b0010);
    req_valid = '0;
    tick();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
